// File: rtl/car_scheduler.sv
// Elevator car controller: SCAN scheduling over latched in-car and hall requests,
// door timing, one-cycle clear pulses for served latches, and emergency stop freeze.
module car_scheduler #(
    parameter int BUTTONS_WIDTH    = 8,
    parameter int TRAVEL_CYCLES    = 4,
    parameter int DOOR_OPEN_CYCLES = 6
) (
    input  logic                     clk,
    input  logic                     an_reset,
    input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
    input  logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:1] active_out_down_levels,
    input  logic                     emergency_stop,
    output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    output logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
    output logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
    output logic                     buttons_block,
    output logic [3:0]               current_floor,
    output logic                     direction,
    output logic                     moving,
    output logic                     door_open
);
    localparam int          W           = BUTTONS_WIDTH;
    localparam logic [15:0] TRAVEL_LOAD = 16'(TRAVEL_CYCLES - 1);
    localparam logic [15:0] DOOR_LOAD   = 16'(DOOR_OPEN_CYCLES - 1);
    localparam logic [3:0]  TOP_FLOOR   = 4'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVING, S_DOOR_OPEN, S_STOPPED} state_t;

    state_t       r_state, r_saved, w_state_nxt, w_saved_nxt;
    logic [3:0]   r_floor, w_floor_nxt;
    logic         r_dir, w_dir_nxt;
    logic [15:0]  r_tcnt, w_tcnt_nxt, r_dcnt, w_dcnt_nxt;
    logic         r_moving, w_moving_nxt, r_door, w_door_nxt, r_block, w_block_nxt;
    logic [W-1:0] r_clr_in, w_clr_in_nxt;
    logic [W-2:0] r_clr_up, w_clr_up_nxt;
    logic [W-1:1] r_clr_dn, w_clr_dn_nxt;

    function automatic logic [W-1:0] f_onehot(input logic [3:0] f);
        f_onehot = '0;
        for (int unsigned i = 0; i < W; i++)
            if (4'(i) == f) f_onehot[i] = 1'b1;
    endfunction

    function automatic logic f_beyond(input logic [W-1:0] req, input logic [3:0] f, input logic up);
        f_beyond = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (up && (4'(i) > f) && req[i]) f_beyond = 1'b1;
            if (!up && (4'(i) < f) && req[i]) f_beyond = 1'b1;
        end
    endfunction

    function automatic logic f_hall(input logic [W-2:0] up_v, input logic [W-1:1] dn_v,
                                    input logic [W-1:0] oh, input logic d);
        f_hall = d ? |(up_v & oh[W-2:0]) : |(dn_v & oh[W-1:1]);
    endfunction

    // A request whose clear pulse is in flight counts as already served.
    logic [W-1:0] w_in, w_req, w_oh_cur, w_oh_step, w_p_oh;
    logic [W-2:0] w_up;
    logic [W-1:1] w_dn;
    logic [3:0]   w_step;
    logic w_here, w_above, w_below, w_go_up, w_go_dn;
    logic w_in_cur, w_hd_cur, w_ho_cur, w_idle_dir, w_door_hit;
    logic w_in_step, w_hd_step, w_beyond_step, w_stop, w_arr_dir;
    logic w_p_en, w_p_dir;

    assign w_in       = active_in_levels & ~r_clr_in;
    assign w_up       = active_out_up_levels & ~r_clr_up;
    assign w_dn       = active_out_down_levels & ~r_clr_dn;
    assign w_req      = w_in | {1'b0, w_up} | {w_dn, 1'b0};
    assign w_oh_cur   = f_onehot(r_floor);
    assign w_here     = |(w_req & w_oh_cur);
    assign w_above    = f_beyond(w_req, r_floor, 1'b1);
    assign w_below    = f_beyond(w_req, r_floor, 1'b0);
    assign w_go_up    = w_above && (r_dir || !w_below);
    assign w_go_dn    = !w_go_up && w_below;
    assign w_in_cur   = |(w_in & w_oh_cur);
    assign w_hd_cur   = f_hall(w_up, w_dn, w_oh_cur, r_dir);
    assign w_ho_cur   = f_hall(w_up, w_dn, w_oh_cur, ~r_dir);
    assign w_idle_dir = (w_in_cur || w_hd_cur || !w_ho_cur) ? r_dir : ~r_dir;
    assign w_door_hit = w_in_cur || w_hd_cur;

    assign w_step        = r_dir ? ((r_floor == TOP_FLOOR) ? r_floor : r_floor + 4'd1)
                                 : ((r_floor == 4'd0) ? r_floor : r_floor - 4'd1);
    assign w_oh_step     = f_onehot(w_step);
    assign w_in_step     = |(w_in & w_oh_step);
    assign w_hd_step     = f_hall(w_up, w_dn, w_oh_step, r_dir);
    assign w_beyond_step = f_beyond(w_req, w_step, r_dir);
    assign w_stop        = w_in_step || w_hd_step || !w_beyond_step;
    // Reverse only when nothing is ahead and no same-direction hall call holds us here.
    assign w_arr_dir     = (w_step == TOP_FLOOR) ? 1'b0 :
                           (w_step == 4'd0) ? 1'b1 :
                           (!w_beyond_step && !w_hd_step) ? ~r_dir : r_dir;

    always_ff @(posedge clk) begin
        if (!an_reset) begin
            r_state  <= S_IDLE;
            r_saved  <= S_IDLE;
            r_floor  <= '0;
            r_dir    <= 1'b1;
            r_tcnt   <= '0;
            r_dcnt   <= '0;
            r_moving <= 1'b0;
            r_door   <= 1'b0;
            r_block  <= 1'b0;
            r_clr_in <= '0;
            r_clr_up <= '0;
            r_clr_dn <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_saved  <= w_saved_nxt;
            r_floor  <= w_floor_nxt;
            r_dir    <= w_dir_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_moving <= w_moving_nxt;
            r_door   <= w_door_nxt;
            r_block  <= w_block_nxt;
            r_clr_in <= w_clr_in_nxt;
            r_clr_up <= w_clr_up_nxt;
            r_clr_dn <= w_clr_dn_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        if (emergency_stop) begin
            w_state_nxt = S_STOPPED;
            if (r_state != S_STOPPED) w_saved_nxt = r_state;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_here)                   w_state_nxt = S_DOOR_OPEN;
                    else if (w_go_up || w_go_dn)  w_state_nxt = S_MOVING;
                end
                S_MOVING:    if (r_tcnt == '0 && w_stop) w_state_nxt = S_DOOR_OPEN;
                S_DOOR_OPEN: if (!w_door_hit && r_dcnt == '0) w_state_nxt = S_IDLE;
                S_STOPPED:   w_state_nxt = r_saved;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_floor_nxt  = r_floor;
        w_dir_nxt    = r_dir;
        w_tcnt_nxt   = r_tcnt;
        w_dcnt_nxt   = r_dcnt;
        w_block_nxt  = 1'b0;
        w_moving_nxt = (w_state_nxt == S_MOVING);
        w_door_nxt   = (w_state_nxt == S_DOOR_OPEN);
        w_p_en       = 1'b0;
        w_p_oh       = w_oh_cur;
        w_p_dir      = r_dir;
        w_clr_in_nxt = '0;
        w_clr_up_nxt = '0;
        w_clr_dn_nxt = '0;
        if (emergency_stop) begin
            w_block_nxt  = 1'b1;
            w_moving_nxt = 1'b0;
            w_door_nxt   = r_door;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_here) begin
                        w_dir_nxt  = w_idle_dir;
                        w_dcnt_nxt = DOOR_LOAD;
                        w_p_en     = 1'b1;
                        w_p_dir    = w_idle_dir;
                    end else if (w_go_up) begin
                        w_dir_nxt  = 1'b1;
                        w_tcnt_nxt = TRAVEL_LOAD;
                    end else if (w_go_dn) begin
                        w_dir_nxt  = 1'b0;
                        w_tcnt_nxt = TRAVEL_LOAD;
                    end
                end
                S_MOVING: begin
                    if (r_tcnt == '0) begin
                        w_floor_nxt = w_step;
                        if (w_stop) begin
                            w_dir_nxt  = w_arr_dir;
                            w_dcnt_nxt = DOOR_LOAD;
                            w_p_en     = 1'b1;
                            w_p_oh     = w_oh_step;
                            w_p_dir    = w_arr_dir;
                        end else begin
                            w_tcnt_nxt = TRAVEL_LOAD;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt - 16'd1;
                    end
                end
                S_DOOR_OPEN: begin
                    if (w_door_hit) begin
                        w_dcnt_nxt = DOOR_LOAD;
                        w_p_en     = 1'b1;
                    end else if (r_dcnt != '0) begin
                        w_dcnt_nxt = r_dcnt - 16'd1;
                    end
                end
                S_STOPPED: begin
                    if (r_saved == S_MOVING)    w_tcnt_nxt = TRAVEL_LOAD;
                    if (r_saved == S_DOOR_OPEN) w_dcnt_nxt = DOOR_LOAD;
                end
                default: ;
            endcase
        end
        if (w_p_en) begin
            w_clr_in_nxt = w_in & w_p_oh;
            w_clr_up_nxt = w_p_dir ? (w_up & w_p_oh[W-2:0]) : '0;
            w_clr_dn_nxt = w_p_dir ? '0 : (w_dn & w_p_oh[W-1:1]);
        end
    end

    assign inactivate_in_levels       = r_clr_in;
    assign inactivate_out_up_levels   = r_clr_up;
    assign inactivate_out_down_levels = r_clr_dn;
    assign buttons_block              = r_block;
    assign current_floor              = r_floor;
    assign direction                  = r_dir;
    assign moving                     = r_moving;
    assign door_open                  = r_door;
endmodule
